// File: rtl/accel_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : accel_seq_pkg
// Purpose  : Shared types and constants for the accelerator test sequencer.
//            FSM state enum, checkpoint code nibbles/bytes, accelerator
//            indices and the job-selection helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package accel_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_ANNOUNCE = 3'd2,
    ST_LAUNCH   = 3'd3,
    ST_WAIT     = 3'd4,
    ST_REPORT   = 3'd5,
    ST_FINISH   = 3'd6
  } seq_state_e;

  // Low nibble of per-job checkpoint codes
  localparam logic [3:0] CODE_START = 4'h0;
  localparam logic [3:0] CODE_END   = 4'h1;
  localparam logic [3:0] CODE_TMO   = 4'hE;

  // Low byte of sequence-level checkpoint codes
  localparam logic [7:0] CODE_DONE  = 8'hFF;
  localparam logic [7:0] CODE_ABORT = 8'hEE;

  // Accelerator indices
  localparam int         NUM_ENG    = 3;
  localparam logic [1:0] ENG_FIR    = 2'd0;
  localparam logic [1:0] ENG_MATMUL = 2'd1;
  localparam logic [1:0] ENG_QSORT  = 2'd2;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } job_sel_t;

  // Lowest selected engine whose index is >= from. from=3 never matches.
  function automatic job_sel_t find_next_job(input logic [2:0] mask,
                                             input logic [1:0] from);
    job_sel_t sel;
    sel = '0;
    if (mask[ENG_FIR] && (from <= ENG_FIR)) begin
      sel.found = 1'b1;
      sel.idx   = ENG_FIR;
    end else if (mask[ENG_MATMUL] && (from <= ENG_MATMUL)) begin
      sel.found = 1'b1;
      sel.idx   = ENG_MATMUL;
    end else if (mask[ENG_QSORT] && (from <= ENG_QSORT)) begin
      sel.found = 1'b1;
      sel.idx   = ENG_QSORT;
    end
    return sel;
  endfunction

  // One-hot engine vector; index 3 shifts out to all-zero.
  function automatic logic [2:0] eng_onehot(input logic [1:0] idx);
    return 3'(3'b001 << idx);
  endfunction

endpackage : accel_seq_pkg
`default_nettype wire

// File: rtl/accel_test_sequencer_hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : seq_hold_timer
// Purpose  : Loadable down-counter with zero flag. Load has priority over
//            decrement; the count saturates at zero instead of wrapping.
// Ports    : clk, rst (async, active-high)
//            load_i/load_val_i : load a new count
//            dec_i             : decrement by one when non-zero
//            zero_o            : count is zero
// Revision : 1.0 - initial release
// ============================================================================
module seq_hold_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule : seq_hold_timer
`default_nettype wire

// File: rtl/accel_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : accel_test_sequencer
// Purpose  : Runs the masked accelerators (0=FIR, 1=matmul, 2=qsort) one at a
//            time in ascending order for a number of passes, publishing
//            checkpoint codes {CODE_PREFIX, idx, nibble} on checkbits_o.
// Ports    : wb_clk_i, wb_rst_i (async, active-high)
//            start_i, abort_i, job_mask_i, passes_i   - control from firmware
//            eng_start_o / eng_done_i                 - accelerator handshake
//            checkbits_o, busy_o, done_o, pass_cnt_o, timeout_o - status
// Config   : SEQ_WATCHDOG_EN - enables the per-job WAIT watchdog and the
//            sticky timeout_o flag; when undefined WAIT waits forever.
// Revision : 1.0 - initial release
// ============================================================================
module accel_test_sequencer
  import accel_seq_pkg::*;
#(
  parameter logic [7:0] CODE_PREFIX    = 8'hAB,
  parameter int         HOLD_CYCLES    = 16,
  parameter int         TIMEOUT_CYCLES = 200000,
  parameter int         PASS_W         = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [NUM_ENG-1:0] job_mask_i,
  input  logic [PASS_W-1:0]  passes_i,
  output logic [NUM_ENG-1:0] eng_start_o,
  input  logic [NUM_ENG-1:0] eng_done_i,
  output logic [15:0]        checkbits_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [PASS_W-1:0]  pass_cnt_o,
  output logic               timeout_o
);

  localparam int              HOLD_W    = $clog2(HOLD_CYCLES + 1);
  // The state's first cycle is spent with the loaded value, so load N-1.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("HOLD_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  seq_state_e               state_q,     state_d;
  logic [NUM_ENG-1:0]       mask_q,      mask_d;
  logic [PASS_W-1:0]        passes_q,    passes_d;
  logic [PASS_W-1:0]        pass_cnt_q,  pass_cnt_d;
  logic [1:0]               job_idx_q,   job_idx_d;
  logic [NUM_ENG-1:0]       eng_start_q, eng_start_d;
  logic [15:0]              checkbits_q, checkbits_d;
  logic                     busy_q,      busy_d;
  logic                     done_q,      done_d;

  logic                     hold_load;
  logic                     hold_dec;
  logic                     hold_zero;
  job_sel_t                 sel;
  logic                     last_pass;

  assign sel       = find_next_job(mask_q, job_idx_q);
  assign last_pass = (pass_cnt_q == (passes_q - PASS_W'(1)));

  seq_hold_timer #(
    .WIDTH (HOLD_W)
  ) u_hold_timer (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .load_i     (hold_load),
    .load_val_i (HOLD_LOAD),
    .dec_i      (hold_dec),
    .zero_o     (hold_zero)
  );

`ifdef SEQ_WATCHDOG_EN
  localparam int            WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  // Loaded in LAUNCH; reaches zero during the TIMEOUT_CYCLES-th WAIT cycle.
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic timeout_q, timeout_d;
  logic wd_load;
  logic wd_dec;
  logic wd_zero;

  seq_hold_timer #(
    .WIDTH (WD_W)
  ) u_watchdog (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .load_i     (wd_load),
    .load_val_i (WD_LOAD),
    .dec_i      (wd_dec),
    .zero_o     (wd_zero)
  );

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    passes_d    = passes_q;
    pass_cnt_d  = pass_cnt_q;
    job_idx_d   = job_idx_q;
    eng_start_d = '0;
    checkbits_d = checkbits_q;
    done_d      = 1'b0;
    hold_load   = 1'b0;
    hold_dec    = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    timeout_d   = timeout_q;
    wd_load     = 1'b0;
    wd_dec      = 1'b0;
`endif

    if (abort_i) begin
      // Abort beats every transition, including a start seen in IDLE.
      state_d     = ST_IDLE;
      checkbits_d = {CODE_PREFIX, CODE_ABORT};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mask_d     = job_mask_i;
            passes_d   = (passes_i == '0) ? PASS_W'(1) : passes_i;
            pass_cnt_d = '0;
            job_idx_d  = '0;
`ifdef SEQ_WATCHDOG_EN
            timeout_d  = 1'b0;
`endif
            state_d    = ST_SELECT;
          end
        end

        ST_SELECT: begin
          if (sel.found) begin
            job_idx_d   = sel.idx;
            checkbits_d = {CODE_PREFIX, 2'b00, sel.idx, CODE_START};
            hold_load   = 1'b1;
            state_d     = ST_ANNOUNCE;
          end else if ((mask_q != '0) && !last_pass) begin
            // Next pass: rescan from engine 0 in the following cycle.
            pass_cnt_d = pass_cnt_q + PASS_W'(1);
            job_idx_d  = '0;
          end else begin
            checkbits_d = {CODE_PREFIX, CODE_DONE};
            done_d      = 1'b1;
            state_d     = ST_FINISH;
          end
        end

        ST_ANNOUNCE: begin
          if (hold_zero) begin
            eng_start_d = eng_onehot(job_idx_q);
            state_d     = ST_LAUNCH;
          end else begin
            hold_dec = 1'b1;
          end
        end

        ST_LAUNCH: begin
`ifdef SEQ_WATCHDOG_EN
          wd_load = 1'b1;
`endif
          state_d = ST_WAIT;
        end

        ST_WAIT: begin
          // Only the active engine's done counts; done wins over expiry.
          if (|(eng_done_i & eng_onehot(job_idx_q))) begin
            checkbits_d = {CODE_PREFIX, 2'b00, job_idx_q, CODE_END};
            hold_load   = 1'b1;
            state_d     = ST_REPORT;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wd_zero) begin
            checkbits_d = {CODE_PREFIX, 2'b00, job_idx_q, CODE_TMO};
            timeout_d   = 1'b1;
            hold_load   = 1'b1;
            state_d     = ST_REPORT;
          end else begin
            wd_dec = 1'b1;
          end
`endif
        end

        ST_REPORT: begin
          if (hold_zero) begin
            job_idx_d = job_idx_q + 2'd1;
            state_d   = ST_SELECT;
          end else begin
            hold_dec = 1'b1;
          end
        end

        ST_FINISH: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      passes_q    <= '0;
      pass_cnt_q  <= '0;
      job_idx_q   <= '0;
      eng_start_q <= '0;
      checkbits_q <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      passes_q    <= passes_d;
      pass_cnt_q  <= pass_cnt_d;
      job_idx_q   <= job_idx_d;
      eng_start_q <= eng_start_d;
      checkbits_q <= checkbits_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEQ_WATCHDOG_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign eng_start_o = eng_start_q;
  assign checkbits_o = checkbits_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_cnt_o  = pass_cnt_q;

endmodule : accel_test_sequencer
`default_nettype wire

// File: doc/accel_test_sequencer.md
Name: accel_test_sequencer

Overview:
- Sequences the three shared user-project accelerators (0 = FIR, 1 = matmul, 2 = qsort) one job at a time.
- Runs the jobs selected by a mask, in ascending index order, for a programmed number of passes.
- Publishes progress codes on a 16-bit checkpoint bus that is routed to mprj_io[31:16].
- Sits between the Wishbone config registers and the accelerator start/done handshakes. Firmware launches a whole regression with one pulse.

Parameters:
- CODE_PREFIX, 8'hAB, upper byte of every checkpoint code.
- HOLD_CYCLES, 16, minimum cycles each start/end code is held before advancing (≥1).
- TIMEOUT_CYCLES, 200000, watchdog limit per job while waiting for done.
- PASS_W, 4, width of the pass-count input.

Ports:
- wb_clk_i  input  1  system clock
- wb_rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  one-cycle pulse; latches job_mask_i and passes_i; ignored while busy_o=1
- abort_i  input  1  level; forces return to IDLE
- job_mask_i  input  3  bit n selects accelerator n
- passes_i  input  PASS_W  number of passes; 0 is treated as 1
- eng_start_o  output  3  one-hot one-cycle start pulse to an accelerator
- eng_done_i  input  3  one-cycle done pulse from each accelerator
- checkbits_o  output  16  checkpoint code
- busy_o  output  1  high from the cycle after start_i until FINISH is left
- done_o  output  1  one-cycle pulse when the sequence completes
- pass_cnt_o  output  PASS_W  index of the current pass, 0-based
- timeout_o  output  1  sticky; set on watchdog expiry, cleared by the next accepted start_i

Behaviour:
- Reset values (async on wb_rst_i): state IDLE; eng_start_o=0, checkbits_o=16'h0000, busy_o=0, done_o=0, pass_cnt_o=0, timeout_o=0; all counters 0.
- FSM states: IDLE, SELECT, ANNOUNCE, LAUNCH, WAIT, REPORT, FINISH.
- IDLE:
  - On start_i, latch the mask and passes (0→1), clear timeout_o, go to SELECT next cycle.
- SELECT:
  - Find the lowest set mask bit with index ≥ job_idx.
  - If one is found → ANNOUNCE.
  - If none is left and the pass just completed is not the last → pass_cnt+1, job_idx=0, stay in SELECT.
  - Otherwise → FINISH.
  - An empty mask goes straight to FINISH.
- ANNOUNCE:
  - checkbits_o = {CODE_PREFIX, job_idx[3:0], 4'h0}.
  - Held exactly HOLD_CYCLES cycles, then → LAUNCH.
- LAUNCH:
  - eng_start_o[job_idx]=1 for exactly one cycle.
  - Reset the watchdog, → WAIT.
- WAIT:
  - Wait for eng_done_i[job_idx]. Done bits of non-active engines are ignored.
  - On done → REPORT with checkbits_o = {PREFIX, idx, 4'h1}.
  - A done arriving in the same cycle as LAUNCH is not sampled; sampling starts the cycle after.
- REPORT:
  - Hold the end code HOLD_CYCLES cycles, then job_idx+1 → SELECT.
- FINISH:
  - checkbits_o = {PREFIX, 8'hFF}, done_o pulses for one cycle, → IDLE.
  - checkbits_o keeps its value in IDLE until the next start.
- Timing: checkbits_o updates on state entry, registered with no glitches. Overall latency per job is 2·HOLD_CYCLES + 2 + engine time.
- abort_i has priority over every transition:
  - next cycle: IDLE, eng_start_o=0, checkbits_o={PREFIX, 8'hEE}, busy_o=0, no done_o pulse.
- start_i together with abort_i in IDLE: abort wins, start is ignored.
- Reset mid-job: all outputs return to reset values immediately. The accelerator is not signalled; firmware resets it.
- Counters saturate rather than wrap:
  - the hold counter is sized $clog2(HOLD_CYCLES+1);
  - the watchdog counter is sized $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro: SEQ_WATCHDOG_EN.
- Defined:
  - The WAIT watchdog counts cycles.
  - At TIMEOUT_CYCLES without done: checkbits_o={PREFIX, idx, 4'hE}, timeout_o=1, then REPORT hold and continue with the next job.
  - If done and expiry fall in the same cycle, done wins.
- Undefined:
  - No watchdog logic exists; WAIT waits indefinitely and timeout_o is tied to 0.

Decomposition:
- Package accel_seq_pkg holds:
  - the state enum;
  - the code nibbles (CODE_START=4'h0, CODE_END=4'h1, CODE_TMO=4'hE);
  - the byte codes (CODE_DONE=8'hFF, CODE_ABORT=8'hEE);
  - the accelerator index constants.
- One sub-module, seq_hold_timer: a loadable down-counter with a zero flag, shared by the hold and watchdog functions and instantiated twice.

Test Plan:
- mask=3'b111, passes=1, each engine model returns done 100 cycles after start:
  - codes AB00→AB01→AB10→AB11→AB20→AB21→ABFF, each held ≥16 cycles;
  - exactly one done_o pulse.
- mask=3'b101, passes=3:
  - eng_start_o[1] never asserts;
  - 6 start pulses in total;
  - pass_cnt_o steps 0,1,2;
  - ends at ABFF.
- mask=3'b000, start pulse:
  - ABFF and a done_o pulse within 3 cycles;
  - no eng_start_o activity.
- mask=3'b010, abort_i asserted during WAIT:
  - next cycle: checkbits=ABEE, busy_o=0, eng_start_o=0;
  - a subsequent start runs normally.
- SEQ_WATCHDOG_EN, TIMEOUT_CYCLES=50, engine 0 never done, mask=3'b011:
  - AB0E at cycle 50 of WAIT, timeout_o=1;
  - sequence continues to AB10/AB11, ABFF.
- Async reset asserted mid-ANNOUNCE:
  - outputs at reset values without a clock edge;
  - start_i pulse while busy_o=1 is ignored: the latched mask is unchanged.
